// File: rtl/mic_capture_ctrl_pkg.sv
// mic_pkg: shared types and constants for the stereo I2S microphone
// capture controller (mic_capture_ctrl and its I2S clock generator).
//   sample_t     - signed 16-bit PCM sample
//   cap_state_t  - capture controller state encoding
//   FRAME_BCLKS  - BCLK periods per stereo frame (32 left + 32 right)
package mic_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_BCLKS = 64;
  localparam int BIT_CNT_W   = $clog2(FRAME_BCLKS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } cap_state_t;

  // True on the last BCLK slot of a frame, i.e. the next falling edge wraps.
  function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
    return cnt == BIT_CNT_W'(FRAME_BCLKS - 1);
  endfunction

endpackage

// File: rtl/mic_capture_ctrl_if.sv
// mic_capture_ctrl_if: sample-in / stereo-pair-out bundle for mic_capture_ctrl.
//   left_valid/left_sample   - one-cycle strobe + sample from left receiver
//   right_valid/right_sample - one-cycle strobe + sample from right receiver
//   pair_valid/pair_ready    - stereo pair handshake (valid held until ready)
//   pair_left/pair_right     - paired samples
//   pair_frame               - RUN frame count latched with each pair; present
//                              only when MIC_CAPTURE_TIMESTAMP_EN is defined
// modport master: the capture controller. modport slave: receivers + consumer.
interface mic_capture_ctrl_if;
  import mic_pkg::*;

  logic    left_valid;
  sample_t left_sample;
  logic    right_valid;
  sample_t right_sample;
  logic    pair_valid;
  logic    pair_ready;
  sample_t pair_left;
  sample_t pair_right;
`ifdef MIC_CAPTURE_TIMESTAMP_EN
  logic [31:0] pair_frame;

  modport master (
    input  left_valid, left_sample, right_valid, right_sample, pair_ready,
    output pair_valid, pair_left, pair_right, pair_frame
  );

  modport slave (
    output left_valid, left_sample, right_valid, right_sample, pair_ready,
    input  pair_valid, pair_left, pair_right, pair_frame
  );
`else
  modport master (
    input  left_valid, left_sample, right_valid, right_sample, pair_ready,
    output pair_valid, pair_left, pair_right
  );

  modport slave (
    output left_valid, left_sample, right_valid, right_sample, pair_ready,
    input  pair_valid, pair_left, pair_right
  );
`endif

endinterface

// File: rtl/mic_capture_ctrl_clk_gen.sv
// i2s_clk_gen: I2S BCLK / LRCLK generator derived from clk.
//   clk, rst   - system clock, synchronous active-high reset
//   run        - advance the divider (controller not idle)
//   clear      - hold all counters and clocks at zero
//   bclk       - bit clock, toggles every BCLK_DIV clk cycles
//   lrclk      - word select, bit 5 of the BCLK counter (0=left, 1=right)
//   frame_tick - high during the clk cycle whose edge wraps bit_cnt 63->0
module i2s_clk_gen
  import mic_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic bclk,
  output logic lrclk,
  output logic frame_tick
);

  localparam int DIV_W = $clog2(BCLK_DIV);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic                 div_wrap;
  logic                 bclk_fall;

  assign div_wrap  = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign bclk_fall = run & div_wrap & bclk;
  assign bit_nxt   = bit_cnt + BIT_CNT_W'(1);
  // Combinational so the controller can change state on the very edge
  // that wraps the frame, keeping the state machine frame-aligned.
  assign frame_tick = bclk_fall & is_last_bit(bit_cnt);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else if (run) begin
      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
        if (bclk) begin
          bit_cnt <= bit_nxt;
          lrclk   <= bit_nxt[BIT_CNT_W-1];
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: stereo I2S microphone capture controller.
// Generates BCLK/LRCLK, discards WARMUP_FRAMES frames after start, then pairs
// left/right receiver samples into stereo pairs with a valid/ready handshake.
//   clk, rst  - system clock, synchronous active-high reset
//   enable    - level request to run the microphones
//   bclk      - I2S bit clock (registered)
//   lrclk     - I2S word select (registered), 0=left 1=right
//   busy      - high in any state except IDLE
//   overrun   - sticky: a pair completed while the previous one was stalled
//   bus       - mic_capture_ctrl_if.master (sample strobes in, pairs out)
// Optional feature: define MIC_CAPTURE_TIMESTAMP_EN to add bus.pair_frame,
// the count of RUN-state frames latched alongside each pair.
module mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int BCLK_DIV      = 16,
  parameter int WARMUP_FRAMES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bclk,
  output logic lrclk,
  output logic busy,
  output logic overrun,
  mic_capture_ctrl_if.master bus
);

  localparam int WARM_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

  cap_state_t        state;
  cap_state_t        state_nxt;
  logic              frame_tick;
  logic              gen_run;
  logic              gen_clear;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_last;

  logic              in_run;
  logic              lv;
  logic              rv;
  logic              have_left;
  logic              pair_done;
  logic              slot_free;
  logic              accept;
  sample_t           left_hold;

  assign gen_run   = (state != ST_IDLE);
  assign gen_clear = (state == ST_IDLE);
  assign busy      = gen_run;
  assign warm_last = (warm_cnt == WARM_W'(WARMUP_FRAMES - 1));

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (gen_run),
    .clear      (gen_clear),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .frame_tick (frame_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (enable) state_nxt = ST_WARMUP;
      ST_WARMUP: begin
        if (!enable)                     state_nxt = ST_STOPPING;
        else if (frame_tick && warm_last) state_nxt = ST_RUN;
      end
      ST_RUN:      if (!enable) state_nxt = ST_STOPPING;
      // Finish the current frame so the clocks stop on a frame boundary.
      ST_STOPPING: if (frame_tick) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != ST_WARMUP) warm_cnt <= '0;
    else if (frame_tick)           warm_cnt <= warm_cnt + WARM_W'(1);
  end

  // Pairing: a right sample completes a pair only if a left sample is held
  // or arrives in the same cycle; strobes outside RUN are ignored.
  assign in_run    = (state == ST_RUN);
  assign lv        = in_run & bus.left_valid;
  assign rv        = in_run & bus.right_valid;
  assign pair_done = rv & (have_left | lv);
  assign accept    = bus.pair_valid & bus.pair_ready;
  assign slot_free = ~bus.pair_valid | bus.pair_ready;

  always_ff @(posedge clk) begin
    if (lv) left_hold <= bus.left_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_left      <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.pair_left  <= '0;
      bus.pair_right <= '0;
      overrun        <= 1'b0;
    end else begin
      if (!in_run || pair_done) have_left <= 1'b0;
      else if (lv)              have_left <= 1'b1;

      if (pair_done && slot_free) begin
        bus.pair_valid <= 1'b1;
        bus.pair_left  <= lv ? bus.left_sample : left_hold;
        bus.pair_right <= bus.right_sample;
      end else if (accept) begin
        bus.pair_valid <= 1'b0;
      end

      // A stalled consumer loses the new pair; the held one stays intact.
      if (pair_done && !slot_free) overrun <= 1'b1;
    end
  end

`ifdef MIC_CAPTURE_TIMESTAMP_EN
  logic [31:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt      <= '0;
      bus.pair_frame <= '0;
    end else begin
      if (in_run && frame_tick)   frame_cnt      <= frame_cnt + 32'd1;
      if (pair_done && slot_free) bus.pair_frame <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with BCLK_DIV=2, WARMUP_FRAMES=2:
// clock timing, warmup length, pairing, handshake, overrun, stop, reset.
module tb_mic_capture_ctrl;

  logic clk;
  logic rst;
  logic enable;
  logic bclk;
  logic lrclk;
  logic busy;
  logic overrun;

  int n_pass  = 0;
  int n_total = 0;

  mic_capture_ctrl_if bus ();

  mic_capture_ctrl #(
    .BCLK_DIV      (2),
    .WARMUP_FRAMES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .busy    (busy),
    .overrun (overrun),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle of receiver strobes, then strobes released.
  task automatic strobe(input logic l, input logic [15:0] ls,
                        input logic r, input logic [15:0] rs);
    bus.left_valid   = l;
    bus.left_sample  = ls;
    bus.right_valid  = r;
    bus.right_sample = rs;
    tick();
    bus.left_valid  = 1'b0;
    bus.right_valid = 1'b0;
  endtask

  // Called just after edge 511 counted from WARMUP entry: strobes on the
  // edge-512 cycle are still in WARMUP, strobes on edge 513 are in RUN.
  // Returns just after edge 514 with the probe pair consumed.
  task automatic enter_run(input string tag);
    strobe(1'b1, 16'h1111, 1'b1, 16'h2222);
    chk({tag, "_warmup_ignored"}, {15'd0, bus.pair_valid}, 16'd0);
    strobe(1'b1, 16'h3333, 1'b1, 16'h4444);
    chk({tag, "_run_pv"}, {15'd0, bus.pair_valid}, 16'd1);
    chk({tag, "_run_left"}, bus.pair_left, 16'h3333);
    chk({tag, "_run_right"}, bus.pair_right, 16'h4444);
    tick();
    chk({tag, "_run_pv_drop"}, {15'd0, bus.pair_valid}, 16'd0);
  endtask

  initial begin
    rst              = 1'b1;
    enable           = 1'b0;
    bus.left_valid   = 1'b0;
    bus.left_sample  = '0;
    bus.right_valid  = 1'b0;
    bus.right_sample = '0;
    bus.pair_ready   = 1'b1;
    tick_n(3);
    chk("rst_bclk",    {15'd0, bclk}, 16'd0);
    chk("rst_lrclk",   {15'd0, lrclk}, 16'd0);
    chk("rst_busy",    {15'd0, busy}, 16'd0);
    chk("rst_pv",      {15'd0, bus.pair_valid}, 16'd0);
    chk("rst_left",    bus.pair_left, 16'h0000);
    chk("rst_right",   bus.pair_right, 16'h0000);
    chk("rst_overrun", {15'd0, overrun}, 16'd0);

    // Start: WARMUP entry edge is W0.
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    chk("w0_busy", {15'd0, busy}, 16'd1);
    chk("w0_bclk", {15'd0, bclk}, 16'd0);
    tick(); chk("w1_bclk", {15'd0, bclk}, 16'd0);
    tick(); chk("w2_bclk", {15'd0, bclk}, 16'd1);
    tick(); chk("w3_bclk", {15'd0, bclk}, 16'd1);
    tick(); chk("w4_bclk", {15'd0, bclk}, 16'd0);
    tick_n(123); chk("w127_lrclk", {15'd0, lrclk}, 16'd0);
    tick();      chk("w128_lrclk", {15'd0, lrclk}, 16'd1);
    tick_n(127); chk("w255_lrclk", {15'd0, lrclk}, 16'd1);
    tick();      chk("w256_lrclk", {15'd0, lrclk}, 16'd0);
    tick_n(255);
    enter_run("first");

    // Left then right, consumer ready.
    strobe(1'b1, 16'h1234, 1'b0, 16'h0000);
    tick();
    chk("lr_no_early_pv", {15'd0, bus.pair_valid}, 16'd0);
    strobe(1'b0, 16'h0000, 1'b1, 16'hABCD);
    chk("lr_pv",    {15'd0, bus.pair_valid}, 16'd1);
    chk("lr_left",  bus.pair_left, 16'h1234);
    chk("lr_right", bus.pair_right, 16'hABCD);
    tick();
    chk("lr_pv_drop", {15'd0, bus.pair_valid}, 16'd0);

    // Orphan right discarded, then a normal pair.
    strobe(1'b0, 16'h0000, 1'b1, 16'h5555);
    chk("orphan_right", {15'd0, bus.pair_valid}, 16'd0);
    strobe(1'b1, 16'h0001, 1'b0, 16'h0000);
    strobe(1'b0, 16'h0000, 1'b1, 16'h0002);
    chk("after_orphan_pv",    {15'd0, bus.pair_valid}, 16'd1);
    chk("after_orphan_left",  bus.pair_left, 16'h0001);
    chk("after_orphan_right", bus.pair_right, 16'h0002);
    tick();

    // Stalled consumer: second pair dropped, overrun set.
    bus.pair_ready = 1'b0;
    strobe(1'b1, 16'h0A0A, 1'b1, 16'h0B0B);
    chk("stall_pv",      {15'd0, bus.pair_valid}, 16'd1);
    chk("stall_no_ovr",  {15'd0, overrun}, 16'd0);
    tick();
    chk("stall_hold_pv", {15'd0, bus.pair_valid}, 16'd1);
    strobe(1'b1, 16'h0C0C, 1'b1, 16'h0D0D);
    chk("ovr_left",  bus.pair_left, 16'h0A0A);
    chk("ovr_right", bus.pair_right, 16'h0B0B);
    chk("ovr_flag",  {15'd0, overrun}, 16'd1);
    chk("ovr_pv",    {15'd0, bus.pair_valid}, 16'd1);
    bus.pair_ready = 1'b1;
    tick();
    chk("ovr_accept_pv", {15'd0, bus.pair_valid}, 16'd0);
    chk("ovr_sticky",    {15'd0, overrun}, 16'd1);
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    chk("ovr_rst_flag", {15'd0, overrun}, 16'd0);
    chk("ovr_rst_pv",   {15'd0, bus.pair_valid}, 16'd0);
    chk("ovr_rst_busy", {15'd0, busy}, 16'd0);
    chk("ovr_rst_left", bus.pair_left, 16'h0000);
    rst = 1'b0;

    // Stop request mid-frame at bit_cnt=10 (edge W552 = RUN entry + 40).
    enable = 1'b1;
    tick();
    tick_n(511);
    enter_run("second");
    tick_n(38);
    enable = 1'b0;
    tick_n(215);
    chk("stop_w767_busy", {15'd0, busy}, 16'd1);
    chk("stop_w767_bclk", {15'd0, bclk}, 16'd1);
    chk("stop_w767_lrclk", {15'd0, lrclk}, 16'd1);
    tick();
    chk("stop_idle_busy",  {15'd0, busy}, 16'd0);
    chk("stop_idle_bclk",  {15'd0, bclk}, 16'd0);
    chk("stop_idle_lrclk", {15'd0, lrclk}, 16'd0);
    tick();
    chk("idle_stays", {15'd0, busy}, 16'd0);

    // Reset mid-RUN with a left sample held.
    enable = 1'b1;
    tick();
    tick_n(511);
    enter_run("third");
    strobe(1'b1, 16'h7777, 1'b0, 16'h0000);
    tick_n(130);
    chk("mid_lrclk", {15'd0, lrclk}, 16'd1);
    chk("mid_busy",  {15'd0, busy}, 16'd1);
    rst = 1'b1;
    tick();
    chk("mrst_bclk",  {15'd0, bclk}, 16'd0);
    chk("mrst_lrclk", {15'd0, lrclk}, 16'd0);
    chk("mrst_busy",  {15'd0, busy}, 16'd0);
    chk("mrst_pv",    {15'd0, bus.pair_valid}, 16'd0);
    chk("mrst_ovr",   {15'd0, overrun}, 16'd0);
    chk("mrst_left",  bus.pair_left, 16'h0000);
    rst = 1'b0;
    tick();
    chk("rewarm_busy", {15'd0, busy}, 16'd1);
    chk("rewarm_bclk", {15'd0, bclk}, 16'd0);
    tick_n(511);
    enter_run("rewarm");
    strobe(1'b0, 16'h0000, 1'b1, 16'h5A5A);
    chk("rewarm_no_stale_left", {15'd0, bus.pair_valid}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
